// File: rtl/serial_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_receiver
//  Description : Receive end of the 16-bit serial word link. Synchronises the
//                asynchronous Receive line, decodes UART frames (1 start bit,
//                8 data bits LSB first, 1 stop bit) and pairs consecutive
//                bytes into 16-bit words, low byte first. Completed words are
//                queued in a show-ahead FIFO that is read with a Valid/Read
//                handshake.
//  Options     : Define SERIAL_RX_PARITY_EN to expect an even-parity bit
//                between data bit 7 and the stop bit.
//  Ports       : Clock      - system clock, rising edge
//                Reset      - synchronous, active-high reset
//                Receive    - serial line, idle high, asynchronous
//                Read       - pop the head word when Valid is 1
//                Valid      - FIFO non-empty
//                DataOut    - head-of-FIFO word, 0 when empty
//                FrameError - sticky bad stop bit / parity flag
//                Overrun    - sticky flag: a word was dropped on a full FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Receive,
    input  logic        Read,
    output logic        Valid,
    output logic [15:0] DataOut,
    output logic        FrameError,
    output logic        Overrun
);

    localparam int c_cw = $clog2(CLKS_PER_BIT);
    localparam int c_aw = $clog2(DEPTH);

    localparam logic [c_cw-1:0] c_full_bit  = c_cw'(CLKS_PER_BIT - 1);
    localparam logic [c_cw-1:0] c_half_bit  = c_cw'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_aw:0]   c_fifo_full = (c_aw + 1)'(DEPTH);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_stop   = 3'd3;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [2:0] c_st_parity = 3'd4;
`endif

    logic            r_rx_meta;
    logic            r_rx_s;
    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [c_cw-1:0] r_cnt;
    logic            w_cnt_done;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            w_sample_data;
    logic            w_byte_ok;
    logic            w_byte_bad;
    logic            w_par_err;
    logic            r_phase_hi;
    logic [7:0]      r_low;
    logic            r_push;
    logic [15:0]     r_push_word;
    logic            r_frame_err;
    logic            r_overrun;
    logic [15:0]     r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;

    // Two-flop synchroniser, preset to the idle (high) line level.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= Receive;
            r_rx_s    <= r_rx_meta;
        end
    end

    // START waits half a bit to land mid-bit; later states wait a whole bit.
    assign w_cnt_done = (r_state == c_st_start) ? (r_cnt == c_half_bit)
                                                : (r_cnt == c_full_bit);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (!r_rx_s) w_state_next = c_st_start;
            end
            c_st_start: begin
                // A line that is high again at mid start bit was a glitch.
                if (w_cnt_done) w_state_next = r_rx_s ? c_st_idle : c_st_data;
            end
            c_st_data: begin
                if (w_cnt_done && (r_bit_idx == 3'd7)) begin
`ifdef SERIAL_RX_PARITY_EN
                    w_state_next = c_st_parity;
`else
                    w_state_next = c_st_stop;
`endif
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            c_st_parity: begin
                if (w_cnt_done) w_state_next = c_st_stop;
            end
`endif
            c_st_stop: begin
                // Back to IDLE at mid stop bit so a following start edge is
                // caught during the remaining half bit.
                if (w_cnt_done) w_state_next = c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

`ifdef SERIAL_RX_PARITY_EN
    logic w_sample_par;
    logic r_par_err;

    // Even parity: data bits plus parity bit must XOR to zero.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_par_err <= 1'b0;
        end else if (w_sample_par) begin
            r_par_err <= ^{r_shift, r_rx_s};
        end
    end

    assign w_par_err = r_par_err;
`else
    assign w_par_err = 1'b0;
`endif

    // Output logic: sampling strobes and byte verdict
    always_comb begin
        w_sample_data = 1'b0;
        w_byte_ok     = 1'b0;
        w_byte_bad    = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        w_sample_par  = 1'b0;
`endif
        case (r_state)
            c_st_data: w_sample_data = w_cnt_done;
`ifdef SERIAL_RX_PARITY_EN
            c_st_parity: w_sample_par = w_cnt_done;
`endif
            c_st_stop: begin
                if (w_cnt_done) begin
                    if (r_rx_s && !w_par_err) w_byte_ok  = 1'b1;
                    else                      w_byte_bad = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Bit timing counter, bit index and LSB-first shift register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if ((r_state == c_st_idle) || w_cnt_done) r_cnt <= '0;
            else                                      r_cnt <= r_cnt + 1'b1;

            if (r_state != c_st_data) r_bit_idx <= '0;
            else if (w_sample_data)   r_bit_idx <= r_bit_idx + 1'b1;

            if (w_sample_data) r_shift <= {r_rx_s, r_shift[7:1]};
        end
    end

    // Byte pairing. A bad byte resynchronises the pair phase to "low" so a
    // lost byte cannot permanently swap the halves of subsequent words.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_phase_hi  <= 1'b0;
            r_low       <= '0;
            r_push      <= 1'b0;
            r_push_word <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (w_byte_ok) begin
                if (r_phase_hi) begin
                    r_push      <= 1'b1;
                    r_push_word <= {r_shift, r_low};
                    r_phase_hi  <= 1'b0;
                end else begin
                    r_low      <= r_shift;
                    r_phase_hi <= 1'b1;
                end
            end else if (w_byte_bad) begin
                r_phase_hi  <= 1'b0;
                r_frame_err <= 1'b1;
            end
        end
    end

    // Show-ahead FIFO. A simultaneous pop frees the slot, so a push into a
    // full FIFO is only dropped when no pop happens in the same cycle.
    assign w_full = (r_count == c_fifo_full);
    assign w_pop  = Read && (r_count != '0);
    assign w_wr   = r_push && (!w_full || w_pop);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (r_push && !w_wr) r_overrun <= 1'b1;
        end
    end

    // Storage needs no reset: DataOut is masked while the FIFO is empty.
    always_ff @(posedge Clock) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_push_word;
    end

    assign Valid      = (r_count != '0);
    assign DataOut    = Valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign FrameError = r_frame_err;
    assign Overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/serial_word_receiver.md
# serial_word_receiver

Receive end of the 16-bit serial word link. Samples the asynchronous `Receive` line, decodes 8N1 UART frames, pairs consecutive bytes into 16-bit words (low byte first) and queues them in a small show-ahead FIFO read with a `Valid`/`Read` handshake. It sits between the board RX pin and the processor's memory-mapped I/O, mirroring the word transmitter so the two can be looped back (`Transmit` to `Receive`) on the bench.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be even and ≥ 4.
- `DEPTH`, 4: FIFO depth in words; power of two, ≥ 2.
- `Clock`  in  1  system clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Receive`  in  1  serial line, idle high, asynchronous to `Clock`.
- `Read`  in  1  pop request; pops the head word on a rising edge when `Valid` is 1.
- `Valid`  out  1  FIFO non-empty.
- `DataOut`  out  16  head-of-FIFO word; 0 when empty.
- `FrameError`  out  1  sticky; set on a bad stop bit (or parity error); cleared only by `Reset`.
- `Overrun`  out  1  sticky; set when a completed word meets a full FIFO; cleared only by `Reset`.

## Operation
- Two-flop synchronizer on `Receive`. All decoding uses the synchronized value `rx_s`.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Bit FSM states and transitions:
  - IDLE: waits for `rx_s` = 0 -> START, bit counter cleared.
  - START: at `CLKS_PER_BIT/2` cycles, samples `rx_s`. If 0 -> DATA. If 1 it is a glitch -> IDLE, with no error flagged.
  - DATA: samples every `CLKS_PER_BIT` cycles (mid-bit). After 8 samples -> STOP (or PARITY when configured).
  - STOP: samples after `CLKS_PER_BIT` cycles.
    - Sample 1: byte accepted.
    - Sample 0: byte discarded, `FrameError` set, byte-pair phase reset to "low".
    - Either way -> IDLE immediately, so the next start edge is detected during the remaining half stop bit.
- Byte pairing:
  - First accepted byte goes to the low holding register, phase -> "high".
  - Second accepted byte forms the word {high, low}, phase -> "low", word pushed.
- FIFO:
  - Push on the cycle after the high byte's stop sample.
  - Pop when `Read` && `Valid`. `Read` while empty is ignored.
  - Push and pop in the same cycle: both occur, count unchanged, including when full.
  - Push while full with no pop: word dropped, `Overrun` set, FIFO contents unchanged.
  - Pointers wrap modulo `DEPTH`. A count of width log2(`DEPTH`)+1 distinguishes full from empty.
- `Reset` at any time, including mid-frame:
  - FSM -> IDLE; FIFO emptied; pair phase -> low; flags cleared.
  - Synchronizer flops preset to 1.
  - A partially received frame is lost.

## Timing
- Reset values: `Valid`=0, `DataOut`=0, `FrameError`=0, `Overrun`=0.
- Start detection delay: 2 cycles of synchronizer latency.
- Stop bit of the high byte is sampled about 9.5 bit times after its start edge, plus 2 cycles.
- Word visible on the cycle after the push edge: `Valid` rises 1 cycle after the push and `DataOut` is valid in the same cycle (show-ahead).
- After a pop edge, `DataOut` shows the next word in the same cycle `Valid` updates. There are no pop bubbles.
- `Read` held high for several cycles pops one word per cycle while `Valid` remains 1.

## Configuration
- `SERIAL_RX_PARITY_EN` defined:
  - Frame carries an even-parity bit between data bit 7 and the stop bit.
  - FSM adds state PARITY, sampled mid-bit.
  - On a parity mismatch the byte is discarded, `FrameError` is set and the pair phase resets to low, exactly as on a stop-bit error.
- `SERIAL_RX_PARITY_EN` undefined: 8N1 only. The PARITY state and its logic are absent.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `DEPTH`=4.
- Reset then idle line -> `Valid`=0, `DataOut`=0, both flags 0. Then send bytes 0xAD, 0x02 -> `Valid`=1, `DataOut`=0x02AD, one pulse of `Read` -> `Valid`=0.
- Start glitch of 4 cycles low, then two good bytes 0x59, 0x01 -> no `FrameError`, one word 0x0159 queued.
- First byte 0x11 sent with stop bit 0, then bytes 0x34, 0x12 -> `FrameError`=1, exactly one word 0x1234 queued (phase resynchronized).
- Five words 0x0001..0x0005 with no reads -> `Valid`=1, `Overrun`=1. Four reads return 0x0001..0x0004, then `Valid`=0.
- FIFO full with `Read` asserted in the push cycle of a fifth word -> `Overrun` stays 0. Reads return 0x0002..0x0005.
- `Reset` asserted mid-DATA of a high byte, then bytes 0x03, 0x00 -> only 0x0003 queued, flags 0.
